// File: rtl/dual_ram_arbiter.sv
// rtl/dual_ram_arbiter.sv - two-client round-robin arbiter in front of a dual-port RAM
//
// Purpose: independent round-robin arbitration of the write port and the read
// port of one dual-port RAM between two client engines. One write and one read
// may issue per cycle. Read data (1-cycle RAM latency) is returned with a
// registered one-hot rd_valid naming its owner.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data      per-client write request, packed client i at slice i
//   wr_gnt                      one-hot write grant (combinational)
//   rd_req/rd_addr              per-client read request, packed like wr_addr
//   rd_gnt                      one-hot read grant (combinational)
//   rd_valid, rd_data           read return, rd_valid registered one-hot owner
//   ram_write/ram_wr_addr/ram_data_in   RAM write port
//   ram_read/ram_rd_addr/ram_data_out   RAM read port (data valid 1 cycle after read)
//
// Configuration: define RAM_BYPASS_EN to return the newly written data when a
// write and a read hit the same address in the same cycle (default: old data).

module dual_ram_arbiter #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             wr_req,
  input  logic [2*ADDR_SIZE-1:0] wr_addr,
  input  logic [2*RAM_WIDTH-1:0] wr_data,
  output logic [1:0]             wr_gnt,
  input  logic [1:0]             rd_req,
  input  logic [2*ADDR_SIZE-1:0] rd_addr,
  output logic [1:0]             rd_gnt,
  output logic [1:0]             rd_valid,
  output logic [RAM_WIDTH-1:0]   rd_data,
  output logic                   ram_write,
  output logic [ADDR_SIZE-1:0]   ram_wr_addr,
  output logic [RAM_WIDTH-1:0]   ram_data_in,
  output logic                   ram_read,
  output logic [ADDR_SIZE-1:0]   ram_rd_addr,
  input  logic [RAM_WIDTH-1:0]   ram_data_out
);

  // Pointer names the client favoured when both request.
  logic wr_pri;
  logic rd_pri;

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic pri);
    if (req == 2'b11) rr_pick = pri ? 2'b10 : 2'b01;
    else              rr_pick = req;
  endfunction

  // Grants are forced low while reset is asserted so nothing reaches the RAM.
  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 2'b00;
    if (!reset) begin
      wr_gnt = rr_pick(wr_req, wr_pri);
      rd_gnt = rr_pick(rd_req, rd_pri);
    end
  end

  // With no grant the muxes fall through to client 0.
  assign ram_write   = |wr_gnt;
  assign ram_wr_addr = wr_gnt[1] ? wr_addr[ADDR_SIZE +: ADDR_SIZE] : wr_addr[0 +: ADDR_SIZE];
  assign ram_data_in = wr_gnt[1] ? wr_data[RAM_WIDTH +: RAM_WIDTH] : wr_data[0 +: RAM_WIDTH];
  assign ram_read    = |rd_gnt;
  assign ram_rd_addr = rd_gnt[1] ? rd_addr[ADDR_SIZE +: ADDR_SIZE] : rd_addr[0 +: ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pri   <= 1'b0;
      rd_pri   <= 1'b0;
      rd_valid <= 2'b00;
    end else begin
      // After serving client i the other client becomes favoured.
      if (wr_gnt[0])      wr_pri <= 1'b1;
      else if (wr_gnt[1]) wr_pri <= 1'b0;
      if (rd_gnt[0])      rd_pri <= 1'b1;
      else if (rd_gnt[1]) rd_pri <= 1'b0;
      rd_valid <= rd_gnt;
    end
  end

`ifdef RAM_BYPASS_EN
  // The RAM returns old contents on a same-address collision; capture the
  // written value so the read sees the new data instead.
  logic                 byp_hit;
  logic [RAM_WIDTH-1:0] byp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= ram_write & ram_read & (ram_wr_addr == ram_rd_addr);
      byp_data <= ram_data_in;
    end
  end

  assign rd_data = byp_hit ? byp_data : ram_data_out;
`else
  assign rd_data = ram_data_out;
`endif

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb/tb_dual_ram_arbiter.sv - self-checking bench for dual_ram_arbiter
module tb_dual_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic [1:0]      wr_req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]      wr_gnt;
  logic [1:0]      rd_req;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]      rd_gnt;
  logic [1:0]      rd_valid;
  logic [DW-1:0]   rd_data;
  logic            ram_write;
  logic [AW-1:0]   ram_wr_addr;
  logic [DW-1:0]   ram_data_in;
  logic            ram_read;
  logic [AW-1:0]   ram_rd_addr;
  logic [DW-1:0]   ram_data_out;

  dual_ram_arbiter #(.RAM_WIDTH(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_write(ram_write), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment: the dual-port RAM (old data on collision, cleared by reset).
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= '0;
      ram_data_out <= '0;
    end else begin
      if (ram_read)  ram_data_out <= ram_mem[ram_rd_addr];
      if (ram_write) ram_mem[ram_wr_addr] <= ram_data_in;
    end
  end

  // Reference model state.
  int            n_checks = 0;
  int            n_fail   = 0;
  int            m_wr_pri = 0;
  int            m_rd_pri = 0;
  logic [DW-1:0] ref_mem [16];
  logic [1:0]    exp_valid = 2'b00;
  logic [DW-1:0] exp_data  = '0;
  bit            known     = 0;
  logic [1:0]    m_wgnt    = 2'b00;
  logic [1:0]    m_rgnt    = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [1:0] req, input int pri);
    if (req[0] && req[1]) return pri;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  // One clock cycle: check outputs against the model, clock, advance the model.
  task automatic step();
    int ww, rw, wi, ri;
    logic [1:0]    ewg, erg;
    logic [AW-1:0] ewa, era;
    logic [DW-1:0] ewd, rv;
    #1;
    ww = reset ? -1 : winner(wr_req, m_wr_pri);
    rw = reset ? -1 : winner(rd_req, m_rd_pri);
    wi = (ww < 0) ? 0 : ww;
    ri = (rw < 0) ? 0 : rw;
    ewg = (ww < 0) ? 2'b00 : 2'(1 << ww);
    erg = (rw < 0) ? 2'b00 : 2'(1 << rw);
    ewa = wr_addr[wi*AW +: AW];
    ewd = wr_data[wi*DW +: DW];
    era = rd_addr[ri*AW +: AW];
    chk("wr_gnt", wr_gnt, ewg);
    chk("ram_write", ram_write, ww >= 0);
    chk("ram_wr_addr", ram_wr_addr, ewa);
    chk("ram_data_in", ram_data_in, ewd);
    chk("rd_gnt", rd_gnt, erg);
    chk("ram_read", ram_read, rw >= 0);
    chk("ram_rd_addr", ram_rd_addr, era);
    if (known) begin
      chk("rd_valid", rd_valid, exp_valid);
      if (exp_valid != 2'b00) chk("rd_data", rd_data, exp_data);
    end
    @(posedge clk);
    if (reset) begin
      m_wr_pri = 0;
      m_rd_pri = 0;
      exp_valid = 2'b00;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      known = 1;
    end else begin
      if (rw >= 0) begin
        rv = ref_mem[era];
`ifdef RAM_BYPASS_EN
        if (ww >= 0 && ewa == era) rv = ewd;
`endif
        exp_data = rv;
        m_rd_pri = (rw == 0) ? 1 : 0;
      end
      exp_valid = erg;
      if (ww >= 0) begin
        ref_mem[ewa] = ewd;
        m_wr_pri = (ww == 0) ? 1 : 0;
      end
    end
    m_wgnt = ewg;
    m_rgnt = erg;
    @(negedge clk);
  endtask

  initial begin
    int c_w0, c_w1, c_r0, c_r1;
    reset = 1'b1;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_addr = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();  // reset state: rd_valid 0, no grants

    // Test 1: single write from client 0.
    wr_req = 2'b01; wr_addr[3:0] = 4'd3; wr_data[7:0] = 8'hA5; wr_data[15:8] = 8'h77;
    #1;
    chk("t1_wr_gnt", wr_gnt, 2'b01);
    chk("t1_ram_write", ram_write, 1'b1);
    chk("t1_wr_addr", ram_wr_addr, 4'd3);
    chk("t1_data_in", ram_data_in, 8'hA5);
    step();
    wr_req = 2'b00;

    // Test 3: client 1 reads back address 3.
    rd_req = 2'b10; rd_addr[7:4] = 4'd3;
    #1 chk("t3_rd_gnt", rd_gnt, 2'b10);
    step();
    rd_req = 2'b00;
    #1;
    chk("t3_rd_valid", rd_valid, 2'b10);
    chk("t3_rd_data", rd_data, 8'hA5);
    step();

    // Test 4: same-cycle write and read of address 5.
    wr_req = 2'b01; wr_addr[3:0] = 4'd5; wr_data[7:0] = 8'h3C;
    rd_req = 2'b10; rd_addr[7:4] = 4'd5;
    step();
    wr_req = 2'b00; rd_req = 2'b00;
`ifdef RAM_BYPASS_EN
    #1 chk("t4_collision", rd_data, 8'h3C);
`else
    #1 chk("t4_collision", rd_data, 8'h00);
`endif
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;

    // Test 2: both clients write continuously, grants alternate from client 0.
    wr_req = 2'b11; wr_addr = {4'd2, 4'd1}; wr_data = {8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_wr_gnt", wr_gnt, (k % 2) ? 2'b10 : 2'b01);
      chk("t2_data_in", ram_data_in, (k % 2) ? 8'h22 : 8'h11);
      step();
    end

    // Test 5: both ports saturated for 6 cycles.
    rd_req = 2'b11; rd_addr = {4'd1, 4'd2};
    c_w0 = 0; c_w1 = 0; c_r0 = 0; c_r1 = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      c_w0 += int'(wr_gnt[0]); c_w1 += int'(wr_gnt[1]);
      c_r0 += int'(rd_gnt[0]); c_r1 += int'(rd_gnt[1]);
      step();
    end
    chk("t5_w0_count", c_w0, 3);
    chk("t5_w1_count", c_w1, 3);
    chk("t5_r0_count", c_r0, 3);
    chk("t5_r1_count", c_r1, 3);
    wr_req = 2'b00; rd_req = 2'b00;
    step();

    // Test 6: reset right after a granted read.
    rd_req = 2'b01; rd_addr[3:0] = 4'd2;
    #1 chk("t6_rd_gnt", rd_gnt, 2'b01);
    step();
    reset = 1'b1;
    #1;
    chk("t6_valid_in_reset", rd_valid, 2'b01);
    chk("t6_rd_gnt_reset", rd_gnt, 2'b00);
    step();
    wr_req = 2'b11;
    #1;
    chk("t6_valid_cleared", rd_valid, 2'b00);
    chk("t6_wr_gnt_reset", wr_gnt, 2'b00);
    step();
    reset = 1'b0;
    rd_req = 2'b11;
    #1;
    chk("t6_wr_pri0", wr_gnt, 2'b01);
    chk("t6_rd_pri0", rd_gnt, 2'b01);
    step();
    #1 chk("t6_no_stale_valid", rd_valid, 2'b01);
    wr_req = 2'b00; rd_req = 2'b00;
    step();

    // Randomized traffic: clients keep req/addr/data stable until granted.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!wr_req[i] || m_wgnt[i]) begin
          wr_req[i] = ($urandom_range(0, 9) < 6);
          wr_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
          wr_data[i*DW +: DW] = DW'($urandom);
        end
        if (!rd_req[i] || m_rgnt[i]) begin
          rd_req[i] = ($urandom_range(0, 9) < 6);
          rd_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
        end
      end
      reset = ($urandom_range(0, 99) < 2);
      step();
    end
    reset = 1'b0;
    wr_req = 2'b00; rd_req = 2'b00;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
